lfsr_8bit_checker: RTL and testbench

Receive-side partner of the 8-bit LFSR generator: a self-synchronising sequence checker for the same XNOR LFSR, polynomial taps 7, 3, 2, 1. It accepts a serial bit stream, seeds a local LFSR from the stream, and verifies the following bits against its own prediction. It then declares lock and counts bit errors. It sits behind any link or bus test path that carries the generator's stream, and provides lock status and error counts to a status register block.

---
 rtl/lfsr_8bit_checker.sv | 184 ++++++++++++++++++
 tb/tb_lfsr_8bit_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_8bit_checker.sv
// lfsr_8bit_checker
//
// Receive-side sequence checker for the 8-bit XNOR LFSR generator
// (taps 7, 3, 2, 1). The checker seeds a local LFSR from the incoming
// serial stream. It verifies a run of predicted bits and then declares
// lock. While locked it runs as a flywheel and counts bit errors. Too
// many errors inside one window drop it back to SEARCH.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   valid_i      : data_i carries a new stream bit this cycle
//   data_i       : received stream bit
//   clr_i        : synchronous clear of err_count_o only
//   locked_o     : checker is in LOCKED (registered)
//   error_o      : one-cycle pulse per mismatching bit while LOCKED
//   err_count_o  : cumulative LOCKED-state errors, saturating
//   state_o      : FSM state, SEARCH=0 VERIFY=1 LOCKED=2
//
// Handshake: valid_i is a qualifier with no back-pressure (there is no
// ready). A bit is accepted on every rising edge where valid_i is high.
// On edges where valid_i is low, no state, counter or output changes.
// The only exceptions are that error_o returns to 0 and clr_i still acts.

module lfsr_8bit_checker #(
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_ERRORS = 4,
  parameter int WINDOW        = 64,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic                 data_i,
  input  logic                 clr_i,
  output logic                 locked_o,
  output logic                 error_o,
  output logic [CNT_WIDTH-1:0] err_count_o,
  output logic [1:0]           state_o
);

  // WINDOW is a power of two, so the bit counter wraps naturally.
  localparam int WB_W = $clog2(WINDOW);
  // The window error count must be able to hold UNLOCK_ERRORS (<= WINDOW).
  localparam int WE_W = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t               r_state;
  logic [7:0]           r_lfsr;
  logic [2:0]           r_fill;
  logic [7:0]           r_match;
  logic [WB_W-1:0]      r_win_bits;
  logic [WE_W-1:0]      r_win_err;
  logic                 r_locked;
  logic                 r_error;
  logic [CNT_WIDTH-1:0] r_err_count;

  state_t               w_state_nx;
  logic [7:0]           w_lfsr_nx;
  logic [2:0]           w_fill_nx;
  logic [7:0]           w_match_nx;
  logic [WB_W-1:0]      w_win_bits_nx;
  logic [WE_W-1:0]      w_win_err_nx;
  logic                 w_error_nx;
  logic [CNT_WIDTH-1:0] w_err_count_nx;

  logic                 w_pred;
  logic                 w_mismatch;
  logic [8:0]           w_match_inc;
  logic                 w_wrap;
  logic [WE_W-1:0]      w_win_err_sum;

  // Next-state and datapath decisions.
  always_comb begin
    w_state_nx     = r_state;
    w_lfsr_nx      = r_lfsr;
    w_fill_nx      = r_fill;
    w_match_nx     = r_match;
    w_win_bits_nx  = r_win_bits;
    w_win_err_nx   = r_win_err;
    w_error_nx     = 1'b0;
    w_err_count_nx = r_err_count;

    w_pred        = ~(r_lfsr[7] ^ r_lfsr[3] ^ r_lfsr[2] ^ r_lfsr[1]);
    w_mismatch    = (data_i != w_pred);
    w_match_inc   = {1'b0, r_match} + 9'd1;
    w_wrap        = (r_win_bits == WB_W'(WINDOW - 1));
    // A bit that wraps the window opens the new window. If that bit is
    // an error, the new window starts with a count of 1.
    w_win_err_sum = w_wrap ? {{(WE_W-1){1'b0}}, w_mismatch}
                           : r_win_err + {{(WE_W-1){1'b0}}, w_mismatch};

    if (valid_i) begin
      case (r_state)
        ST_SEARCH: begin
          w_lfsr_nx = {r_lfsr[6:0], data_i};
          if (r_fill == 3'd7) begin
            w_state_nx = ST_VERIFY;
            w_match_nx = 8'd0;
            w_fill_nx  = 3'd0;
          end else begin
            w_fill_nx = r_fill + 3'd1;
          end
        end

        ST_VERIFY: begin
          w_lfsr_nx = {r_lfsr[6:0], w_pred};
          // All-ones is the XNOR lock-up state. It would "verify" a
          // constant-1 stream forever, so it is always rejected.
          if (r_lfsr == 8'hFF || w_mismatch) begin
            w_state_nx = ST_SEARCH;
            w_fill_nx  = 3'd0;
          end else if (w_match_inc == 9'(LOCK_COUNT)) begin
            w_state_nx    = ST_LOCKED;
            w_win_bits_nx = '0;
            w_win_err_nx  = '0;
          end else begin
            w_match_nx = w_match_inc[7:0];
          end
        end

        ST_LOCKED: begin
          // Flywheel: the register follows its own prediction, so a bad
          // received bit never propagates into later predictions.
          w_lfsr_nx     = {r_lfsr[6:0], w_pred};
          w_error_nx    = w_mismatch;
          w_win_bits_nx = r_win_bits + 1'b1;
          w_win_err_nx  = w_win_err_sum;
          if (w_win_err_sum == WE_W'(UNLOCK_ERRORS)) begin
            w_state_nx = ST_SEARCH;
            w_fill_nx  = 3'd0;
          end
        end

        default: begin
          w_state_nx = ST_SEARCH;
          w_fill_nx  = 3'd0;
        end
      endcase
    end

    // A clear in the same cycle as an error leaves exactly that error.
    if (clr_i) begin
      w_err_count_nx = w_error_nx ? CNT_WIDTH'(1) : '0;
    end else if (w_error_nx && (r_err_count != {CNT_WIDTH{1'b1}})) begin
      w_err_count_nx = r_err_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_SEARCH;
      r_lfsr      <= 8'd0;
      r_fill      <= 3'd0;
      r_match     <= 8'd0;
      r_win_bits  <= '0;
      r_win_err   <= '0;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_lfsr      <= w_lfsr_nx;
      r_fill      <= w_fill_nx;
      r_match     <= w_match_nx;
      r_win_bits  <= w_win_bits_nx;
      r_win_err   <= w_win_err_nx;
      r_locked    <= (w_state_nx == ST_LOCKED);
      r_error     <= w_error_nx;
      r_err_count <= w_err_count_nx;
    end
  end

  assign locked_o    = r_locked;
  assign error_o     = r_error;
  assign err_count_o = r_err_count;
  assign state_o     = r_state;

endmodule

// File: tb/tb_lfsr_8bit_checker.sv
// Directed testbench for lfsr_8bit_checker.
// The main instance uses default parameters. A second instance
// (CNT_WIDTH=4, UNLOCK_ERRORS=WINDOW=64) exercises counter saturation.

module tb_lfsr_8bit_checker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_s, valid, data, clr;
  logic        locked, error, locked_s, error_s;
  logic [15:0] cnt;
  logic [3:0]  cnt_s;
  logic [1:0]  state, state_s;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] g;

  lfsr_8bit_checker dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data), .clr_i(clr),
    .locked_o(locked), .error_o(error), .err_count_o(cnt), .state_o(state)
  );

  lfsr_8bit_checker #(
    .LOCK_COUNT(16), .UNLOCK_ERRORS(64), .WINDOW(64), .CNT_WIDTH(4)
  ) dut_s (
    .clk_i(clk), .rst_i(rst_s), .valid_i(valid), .data_i(data), .clr_i(clr),
    .locked_o(locked_s), .error_o(error_s), .err_count_o(cnt_s), .state_o(state_s)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are applied, one edge is taken, and outputs are then valid #1 later.
  task automatic send_bit(input logic v, input logic d, input logic c);
    valid = v;
    data  = d;
    clr   = c;
    @(posedge clk);
    #1;
    valid = 1'b0;
    clr   = 1'b0;
  endtask

  // Advance the reference generator (seed 0) and send its bit, optionally inverted.
  task automatic send_gen(input logic flip, input logic c);
    logic fb;
    fb = ~(g[7] ^ g[3] ^ g[2] ^ g[1]);
    g  = {g[6:0], fb};
    send_bit(1'b1, fb ^ flip, c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    g   = 8'h00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic        bad;
    logic [20:0] prev;
    int          acc;
    int          cyc;

    rst = 1'b1; rst_s = 1'b1; valid = 1'b0; data = 1'b0; clr = 1'b0; g = 8'h00;

    // ---- reset state ----
    do_reset();
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_error",  32'(error),  32'd0);
    check("rst_count",  32'(cnt),    32'd0);
    check("rst_state",  32'(state),  32'd0);

    // ---- clean stream, 1000 bits ----
    bad = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      send_gen(1'b0, 1'b0);
      if (i == 7)  check("clean_state_b7",  32'(state),  32'd0);
      if (i == 8)  check("clean_state_b8",  32'(state),  32'd1);
      if (i == 23) check("clean_locked_b23", 32'(locked), 32'd0);
      if (i == 24) begin
        check("clean_locked_b24", 32'(locked), 32'd1);
        check("clean_state_b24",  32'(state),  32'd2);
      end
      if (i > 24 && (error !== 1'b0 || cnt !== 16'd0 || locked !== 1'b1)) bad = 1'b1;
    end
    check("clean_no_errors", 32'(bad), 32'd0);

    // ---- three single flips, spaced 10 apart ----
    for (int i = 0; i < 30; i++) begin
      send_gen(1'((i % 10) == 0), 1'b0);
      check("flip_error_pulse", 32'(error), 32'((i % 10) == 0));
    end
    check("flip_count",  32'(cnt),    32'd3);
    check("flip_locked", 32'(locked), 32'd1);

    // ---- clr_i alone, then clr_i with an error ----
    repeat (70) send_gen(1'b0, 1'b0);
    send_gen(1'b0, 1'b1);
    check("clr_only_count", 32'(cnt), 32'd0);
    send_gen(1'b1, 1'b1);
    check("clr_err_count",  32'(cnt),    32'd1);
    check("clr_err_pulse",  32'(error),  32'd1);
    check("clr_err_locked", 32'(locked), 32'd1);

    // ---- unlock on 4th error in a window ----
    do_reset();
    repeat (24) send_gen(1'b0, 1'b0);
    check("unl_locked", 32'(locked), 32'd1);
    for (int i = 1; i <= 14; i++) begin
      send_gen(1'(i >= 11), 1'b0);
      if (i == 13) check("unl_state_3err", 32'(state), 32'd2);
    end
    check("unl_state",  32'(state),  32'd0);
    check("unl_locked0", 32'(locked), 32'd0);
    check("unl_pulse",  32'(error),  32'd1);
    check("unl_count",  32'(cnt),    32'd4);
    for (int i = 1; i <= 24; i++) begin
      send_gen(1'b0, 1'b0);
      if (i == 23) check("relock_b23", 32'(locked), 32'd0);
      if (i == 24) check("relock_b24", 32'(locked), 32'd1);
    end

    // ---- window wrap: 3 errors, wrap (wrapping bit is an error), 2 more, then one more ----
    for (int i = 1; i <= 90; i++) begin
      send_gen(1'(i == 10 || i == 20 || i == 30 || i == 64 || i == 70 || i == 80 || i == 90), 1'b0);
      if (i == 64) check("win_locked_b64", 32'(locked), 32'd1);
      if (i == 80) check("win_state_b80",  32'(state),  32'd2);
    end
    check("win_unlock_b90", 32'(state), 32'd0);
    check("win_count",      32'(cnt),   32'd11);

    // ---- VERIFY failure at bit 12 ----
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      send_gen(1'(i == 12), 1'b0);
      if (i == 11) check("vf_state_b11", 32'(state), 32'd1);
    end
    check("vf_state", 32'(state), 32'd0);
    check("vf_error", 32'(error), 32'd0);
    check("vf_count", 32'(cnt),   32'd0);

    // ---- gapped valid ----
    do_reset();
    acc = 0; cyc = 0; bad = 1'b0;
    while (acc < 24 && cyc < 2000) begin
      cyc++;
      if ($urandom_range(0, 1) == 1) begin
        send_gen(1'b0, 1'b0);
        acc++;
        if (error !== 1'b0) bad = 1'b1;
        if (acc == 23) check("gap_locked_23", 32'(locked), 32'd0);
        if (acc == 24) check("gap_locked_24", 32'(locked), 32'd1);
      end else begin
        prev = {locked, error, cnt, state, 1'b0};
        send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        if ({locked, error, cnt, state, 1'b0} !== prev) bad = 1'b1;
      end
    end
    check("gap_accepted", 32'(acc), 32'd24);
    check("gap_idle_stable", 32'(bad), 32'd0);
    check("gap_count", 32'(cnt), 32'd0);

    // ---- constant-1 stream never locks ----
    do_reset();
    bad = 1'b0;
    repeat (200) begin
      send_bit(1'b1, 1'b1, 1'b0);
      if (locked !== 1'b0 || state === 2'd2) bad = 1'b1;
    end
    check("ones_never_lock", 32'(bad), 32'd0);

    // ---- reset mid-LOCKED ----
    do_reset();
    repeat (24) send_gen(1'b0, 1'b0);
    send_gen(1'b1, 1'b0);
    check("mr_pre_error", 32'(error), 32'd1);
    check("mr_pre_count", 32'(cnt),   32'd1);
    rst = 1'b1;
    send_gen(1'b1, 1'b0);
    check("mr_locked", 32'(locked), 32'd0);
    check("mr_error",  32'(error),  32'd0);
    check("mr_count",  32'(cnt),    32'd0);
    check("mr_state",  32'(state),  32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      send_gen(1'b0, 1'b0);
      if (i == 23) check("mr_relock_b23", 32'(locked), 32'd0);
      if (i == 24) check("mr_relock_b24", 32'(locked), 32'd1);
    end

    // ---- saturation, CNT_WIDTH=4 ----
    rst_s = 1'b1;
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    rst_s = 1'b0;
    g = 8'h00;
    check("sat_rst_count", 32'(cnt_s), 32'd0);
    repeat (24) send_gen(1'b0, 1'b0);
    check("sat_locked", 32'(locked_s), 32'd1);
    repeat (20) send_gen(1'b1, 1'b0);
    check("sat_count",       32'(cnt_s),    32'd15);
    check("sat_still_locked", 32'(locked_s), 32'd1);

    // ---- report ----
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
